// File: rtl/cnn_pkg.sv
// Shared constants and types for the second convolution layer and its post-processing.
package cnn_pkg;

  localparam int CONV2_CH       = 3;
  localparam int CONV2_IN_BITS  = 14;
  localparam int CONV2_SUM_BITS = CONV2_IN_BITS + 1;
  localparam int CONV2_OUT_W    = 12;

  // Per-channel bias added before ReLU, fixed at build time.
  localparam logic signed [7:0] CONV2_BIAS [CONV2_CH] = '{8'sd0, 8'sd0, 8'sd5};

  typedef logic signed [CONV2_IN_BITS-1:0] conv2_in_t;
  typedef logic [CONV2_OUT_W-1:0]          conv2_pix_t;

endpackage

// File: rtl/conv2_relu_pool_if.sv
// Stream bundle between the conv-2 sum calculators, the pooling stage and the flatten stage.
interface conv2_relu_pool_if #(
  parameter int OUT_W = 12
);
  import cnn_pkg::*;

  logic              valid_in;
  conv2_in_t         conv_in_1;
  conv2_in_t         conv_in_2;
  conv2_in_t         conv_in_3;
  logic [OUT_W-1:0]  pool_out_1;
  logic [OUT_W-1:0]  pool_out_2;
  logic [OUT_W-1:0]  pool_out_3;
  logic              valid_out;
  logic              frame_done;

  modport master (
    output valid_in, conv_in_1, conv_in_2, conv_in_3,
    input  pool_out_1, pool_out_2, pool_out_3, valid_out, frame_done
  );

  modport slave (
    input  valid_in, conv_in_1, conv_in_2, conv_in_3,
    output pool_out_1, pool_out_2, pool_out_3, valid_out, frame_done
  );

endinterface

// File: rtl/conv2_relu_pool_line.sv
// One channel of 2x2/stride-2 max pooling: horizontal pair register, half-width
// line buffer holding the even-row pair maxima, and the registered window output.
module pool2x2_line #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 12,
  parameter int COL_W = $clog2(IN_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [COL_W-1:0] col_i,
  input  logic             row_odd_i,
  input  logic [OUT_W-1:0] pix_i,
  output logic [OUT_W-1:0] pix_o
);

  localparam int DEPTH = IN_W / 2;

  logic [OUT_W-1:0] pair_q, pair_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] line_mem [DEPTH];
  logic [OUT_W-1:0] pair_max;
  logic [OUT_W-1:0] above;
  logic             line_we;
  logic [COL_W-2:0] idx;

  assign idx   = col_i[COL_W-1:1];
  assign above = line_mem[idx];

  always_comb begin
    pair_d   = pair_q;
    out_d    = out_q;
    line_we  = 1'b0;
    pair_max = (pix_i > pair_q) ? pix_i : pair_q;
    if (valid_i) begin
      if (!col_i[0]) begin
        pair_d = pix_i;
      end else if (!row_odd_i) begin
        line_we = 1'b1;
      end else begin
        out_d = (pair_max > above) ? pair_max : above;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pair_q <= '0;
      out_q  <= '0;
    end else begin
      pair_q <= pair_d;
      out_q  <= out_d;
    end
  end

  // NOTE: the line buffer has no reset; each entry is written on an even row before
  // the odd row reads it, so a reset here would only cost a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (line_we) line_mem[idx] <= pair_max;
  end

  assign pix_o = out_q;

endmodule

// File: rtl/conv2_relu_pool.sv
// Bias + ReLU + 2x2 max pooling after the conv-2 sum calculators, three channels.
// Build option CONV2_RELU_SAT_EN: clamp post-ReLU values to OUT_W bits instead of wrapping.
module conv2_relu_pool
  import cnn_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int IN_H  = 10,
  parameter int OUT_W = CONV2_OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  conv2_relu_pool_if.slave  bus
);

  localparam int COL_W = $clog2(IN_W + 1);
  localparam int ROW_W = $clog2(IN_H + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_H - 1);
  localparam logic signed [CONV2_SUM_BITS-1:0] PIX_MAX = CONV2_SUM_BITS'((1 << OUT_W) - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_row_odd_q, s1_row_odd_d;
  logic [COL_W-1:0] s1_col_q, s1_col_d;
  logic [OUT_W-1:0] s1_pix_q [CONV2_CH];
  logic [OUT_W-1:0] s1_pix_d [CONV2_CH];
  logic             valid_out_q, valid_out_d;
  logic             frame_done_q, frame_done_d;
  conv2_in_t        conv_in  [CONV2_CH];
  logic [OUT_W-1:0] pool_pix [CONV2_CH];

  assign conv_in[0] = bus.conv_in_1;
  assign conv_in[1] = bus.conv_in_2;
  assign conv_in[2] = bus.conv_in_3;

  function automatic logic [OUT_W-1:0] relu_reduce(input logic signed [CONV2_SUM_BITS-1:0] s);
    logic [OUT_W-1:0] r;
    if (s < 0) begin
      r = '0;
`ifdef CONV2_RELU_SAT_EN
    end else if (s > PIX_MAX) begin
      r = '1;
`endif
    end else begin
      r = s[OUT_W-1:0];
    end
    return r;
  endfunction

  // NOTE: every always_comb output gets its default first, so no path leaves one unassigned (no latch).
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    s1_valid_d   = bus.valid_in;
    s1_col_d     = col_q;
    s1_row_odd_d = row_q[0];
    s1_last_d    = (col_q == LAST_COL) && (row_q == LAST_ROW);
    for (int c = 0; c < CONV2_CH; c++) begin
      s1_pix_d[c] = relu_reduce({conv_in[c][CONV2_IN_BITS-1], conv_in[c]}
                                + {{(CONV2_SUM_BITS-8){CONV2_BIAS[c][7]}}, CONV2_BIAS[c]});
    end
    if (bus.valid_in) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    // A window completes on the odd column of an odd row.
    valid_out_d  = s1_valid_q && s1_col_q[0] && s1_row_odd_q;
    frame_done_d = valid_out_d && s1_last_q;
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_row_odd_q <= 1'b0;
      s1_col_q     <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int c = 0; c < CONV2_CH; c++) s1_pix_q[c] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_row_odd_q <= s1_row_odd_d;
      s1_col_q     <= s1_col_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      for (int c = 0; c < CONV2_CH; c++) s1_pix_q[c] <= s1_pix_d[c];
    end
  end

  for (genvar c = 0; c < CONV2_CH; c++) begin : g_ch
    pool2x2_line #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .COL_W (COL_W)
    ) u_line (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (s1_valid_q),
      .col_i     (s1_col_q),
      .row_odd_i (s1_row_odd_q),
      .pix_i     (s1_pix_q[c]),
      .pix_o     (pool_pix[c])
    );
  end

  assign bus.pool_out_1 = pool_pix[0];
  assign bus.pool_out_2 = pool_pix[1];
  assign bus.pool_out_3 = pool_pix[2];
  assign bus.valid_out  = valid_out_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2_relu_pool.sv
// Directed bench for conv2_relu_pool: table of constant-frame vectors plus ramp frames,
// gapped input, mid-frame resets and back-to-back frames against a small reference model.
module tb_conv2_relu_pool;
  import cnn_pkg::*;

  localparam int IN_W  = 10;
  localparam int IN_H  = 10;
  localparam int OUT_W = 12;
  localparam int PW    = IN_W / 2;
  localparam int PH    = IN_H / 2;
  localparam int BIAS [3] = '{0, 0, 5};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv2_relu_pool_if #(.OUT_W(OUT_W)) bus ();

  conv2_relu_pool #(
    .IN_W  (IN_W),
    .IN_H  (IN_H),
    .OUT_W (OUT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] p1, p2, p3;
    logic [31:0] fd;
    logic [31:0] cyc;
  } out_t;

  typedef struct {
    int in1, in2, in3;
    int e1, e2, e3;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   stray_fd = 0;
  int   cur_in [3];
  out_t got_q [$];
  out_t exp_q [$];
  int   vin_cyc_q [$];
  vec_t vecs [6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_out === 1'b1)
      got_q.push_back('{32'(bus.pool_out_1), 32'(bus.pool_out_2), 32'(bus.pool_out_3),
                        32'(bus.frame_done), 32'(cyc)});
    else if (bus.frame_done !== 1'b0)
      stray_fd++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int red(input int v);
    if (v < 0) return 0;
`ifdef CONV2_RELU_SAT_EN
    if (v > 4095) return 4095;
`endif
    return v & 4095;
  endfunction

  function automatic int raw(input int mode, input int ch, input int r, input int c);
    int p = r * 10 + c;
    case (mode)
      1: case (ch) 0: return p; 1: return p * 60; default: return p - 50; endcase
      2: case (ch) 0: return 99 - p; 1: return (r * 3 + c * 7) % 40; default: return 20 - p; endcase
      default: return cur_in[ch];
    endcase
  endfunction

  function automatic int model(input int mode, input int ch, input int pr, input int pc);
    int m = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        int v = red(raw(mode, ch, 2 * pr + dr, 2 * pc + dc) + BIAS[ch]);
        if (v > m) m = v;
      end
    return m;
  endfunction

  task automatic push_expect(input int mode);
    for (int pr = 0; pr < PH; pr++)
      for (int pc = 0; pc < PW; pc++)
        exp_q.push_back('{32'(model(mode, 0, pr, pc)), 32'(model(mode, 1, pr, pc)),
                          32'(model(mode, 2, pr, pc)),
                          32'((pr == PH - 1) && (pc == PW - 1)), 32'd0});
  endtask

  task automatic push_const(input int e1, input int e2, input int e3);
    for (int i = 0; i < PW * PH; i++)
      exp_q.push_back('{32'(e1), 32'(e2), 32'(e3), 32'(i == PW * PH - 1), 32'd0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_pixel(input int mode, input int r, input int c, input int gap);
    bus.conv_in_1 = 14'(raw(mode, 0, r, c));
    bus.conv_in_2 = 14'(raw(mode, 1, r, c));
    bus.conv_in_3 = 14'(raw(mode, 2, r, c));
    bus.valid_in  = 1'b1;
    if ((r % 2 == 1) && (c % 2 == 1)) vin_cyc_q.push_back(cyc);
    step();
    if (gap != 0) begin
      bus.valid_in = 1'b0;
      step();
    end
  endtask

  task automatic drive_frame(input int mode, input int gap);
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        drive_pixel(mode, r, c, gap);
  endtask

  task automatic drive_prefix(input int mode, input int n);
    for (int i = 0; i < n; i++) drive_pixel(mode, i / IN_W, i % IN_W, 0);
  endtask

  task automatic pulse_reset();
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    vin_cyc_q.delete();
  endtask

  task automatic compare(input string name);
    int n;
    idle(4);
    check({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d] ch1", name, i), got_q[i].p1, exp_q[i].p1);
      check($sformatf("%s[%0d] ch2", name, i), got_q[i].p2, exp_q[i].p2);
      check($sformatf("%s[%0d] ch3", name, i), got_q[i].p3, exp_q[i].p3);
      check($sformatf("%s[%0d] frame_done", name, i), got_q[i].fd, exp_q[i].fd);
    end
    n = (got_q.size() < vin_cyc_q.size()) ? got_q.size() : vin_cyc_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d] latency", name, i), got_q[i].cyc - 32'(vin_cyc_q[i]), 32'd2);
    clear_all();
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 0, 5};
    vecs[1] = '{-100, -100, -100, 0, 0, 0};
    vecs[2] = '{-3, -3, -3, 0, 0, 2};
`ifdef CONV2_RELU_SAT_EN
    vecs[3] = '{100, 4095, 4091, 100, 4095, 4095};
    vecs[4] = '{5000, 5000, 5000, 4095, 4095, 4095};
    vecs[5] = '{8191, -8192, 8191, 4095, 0, 4095};
`else
    vecs[3] = '{100, 4095, 4091, 100, 4095, 0};
    vecs[4] = '{5000, 5000, 5000, 904, 904, 909};
    vecs[5] = '{8191, -8192, 8191, 4095, 0, 4};
`endif

    rst_n         = 1'b1;
    bus.valid_in  = 1'b0;
    bus.conv_in_1 = '0;
    bus.conv_in_2 = '0;
    bus.conv_in_3 = '0;
    step();
    step();
    check("reset valid_out", 32'(bus.valid_out), 32'd0);
    check("reset frame_done", 32'(bus.frame_done), 32'd0);
    check("reset pool_out_1", 32'(bus.pool_out_1), 32'd0);
    check("reset pool_out_2", 32'(bus.pool_out_2), 32'd0);
    check("reset pool_out_3", 32'(bus.pool_out_3), 32'd0);
    rst_n = 1'b0;
    idle(2);
    check("idle valid_out", 32'(got_q.size()), 32'd0);

    // Ramp frame, continuous input.
    push_expect(1);
    drive_frame(1, 0);
    idle(4);
    if (got_q.size() >= 25) begin
      check("ramp first ch1", got_q[0].p1, 32'd11);
      check("ramp last ch1", got_q[24].p1, 32'd99);
      check("ramp spacing", got_q[1].cyc - got_q[0].cyc, 32'd2);
    end else begin
      check("ramp output count", 32'(got_q.size()), 32'd25);
    end
    compare("ramp");

    // Constant frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      cur_in[0] = vecs[v].in1;
      cur_in[1] = vecs[v].in2;
      cur_in[2] = vecs[v].in3;
      push_const(vecs[v].e1, vecs[v].e2, vecs[v].e3);
      drive_frame(0, 0);
      compare($sformatf("vec%0d", v));
    end

    // Ramp frame with valid_in toggling every cycle.
    push_expect(1);
    drive_frame(1, 1);
    idle(4);
    if (got_q.size() >= 2)
      check("gapped spacing", got_q[1].cyc - got_q[0].cyc, 32'd4);
    else
      check("gapped output count", 32'(got_q.size()), 32'd25);
    compare("gapped");

    // Reset after 37 inputs: only the 8 windows completed before reset appear.
    drive_prefix(2, 37);
    pulse_reset();
    idle(6);
    check("reset37 prefix outputs", 32'(got_q.size()), 32'd8);
    clear_all();
    push_expect(2);
    drive_frame(2, 0);
    compare("after_reset37");

    // Reset while a completed window is still in stage 1: that window is dropped.
    drive_prefix(1, 16);
    pulse_reset();
    idle(6);
    check("reset16 prefix outputs", 32'(got_q.size()), 32'd2);
    clear_all();
    push_expect(1);
    drive_frame(1, 0);
    compare("after_reset16");

    // Two frames back to back with different data.
    push_expect(1);
    push_expect(2);
    drive_frame(1, 0);
    drive_frame(2, 0);
    compare("b2b");

    check("stray frame_done", 32'(stray_fd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
